vga_timing_gen: RTL and testbench

Free-running VGA raster timing generator that produces the horizontal and vertical counter, sync, and blanking stream consumed by the pixel pipeline stages (rectangle/image overlay, background drawing). It sits at the head of the video chain and is driven by the pixel clock. Every output is registered so that counts, syncs and blanks are mutually aligned on the same pclk edge. It also provides a one-cycle frame-start strobe for frame-synchronous logic such as position latching.

---
 rtl/vga_timing_gen.sv | 79 +++++++
 tb/tb_vga_timing_gen.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator.
// Counts, syncs, blanks and frame strobe are all flop outputs aligned on the same pclk edge.
module vga_timing_gen #(
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BACK    = 88,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 23,
    parameter int SYNC_POL  = 1
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        en,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_LO = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_HI = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_LO = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_HI = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic        ACT       = (SYNC_POL != 0);

    logic [10:0] h_next;
    logic [10:0] v_next;
    logic        h_wrap;
    logic        hs_next;
    logic        vs_next;

    // Decodes look at the next counts so they land in the same cycle as them.
    always_comb begin
        h_wrap  = (hcount_out == H_LAST);
        h_next  = h_wrap ? 11'd0 : hcount_out + 11'd1;
        v_next  = vcount_out;
        if (h_wrap) begin
            v_next = (vcount_out == V_LAST) ? 11'd0 : vcount_out + 11'd1;
        end
        hs_next = (h_next >= H_SYNC_LO) && (h_next < H_SYNC_HI);
        vs_next = (v_next >= V_SYNC_LO) && (v_next < V_SYNC_HI);
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_out  <= 11'd0;
            vcount_out  <= 11'd0;
            hsync_out   <= ~ACT;
            vsync_out   <= ~ACT;
            hblnk_out   <= 1'b0;
            vblnk_out   <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            hcount_out  <= h_next;
            vcount_out  <= v_next;
            hsync_out   <= hs_next ? ACT : ~ACT;
            vsync_out   <= vs_next ? ACT : ~ACT;
            hblnk_out   <= (h_next >= H_VIS_END);
            vblnk_out   <= (v_next >= V_VIS_END);
            frame_start <= (h_next == 11'd0) && (v_next == 11'd0);
        end else begin
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default build for line timing,
// small builds (both sync polarities) for frame, gating and reset cases.
module tb_vga_timing_gen;

    logic pclk = 1'b0;
    logic rst_n;
    logic en;

    always #5 pclk = ~pclk;

    logic [10:0] d_hcount, d_vcount;
    logic        d_hsync, d_vsync, d_hblnk, d_vblnk, d_fs;
    logic [10:0] s_hcount, s_vcount;
    logic        s_hsync, s_vsync, s_hblnk, s_vblnk, s_fs;
    logic [10:0] n_hcount, n_vcount;
    logic        n_hsync, n_vsync, n_hblnk, n_vblnk, n_fs;

    vga_timing_gen u_dut (
        .pclk(pclk), .rst_n(rst_n), .en(en),
        .hcount_out(d_hcount), .vcount_out(d_vcount),
        .hsync_out(d_hsync), .vsync_out(d_vsync),
        .hblnk_out(d_hblnk), .vblnk_out(d_vblnk),
        .frame_start(d_fs)
    );

    // Small raster: H 16+2+4+3 = 25, V 10+1+2+3 = 16, frame = 400 cycles.
    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_VISIBLE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
        .SYNC_POL(1)
    ) u_small (
        .pclk(pclk), .rst_n(rst_n), .en(en),
        .hcount_out(s_hcount), .vcount_out(s_vcount),
        .hsync_out(s_hsync), .vsync_out(s_vsync),
        .hblnk_out(s_hblnk), .vblnk_out(s_vblnk),
        .frame_start(s_fs)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_VISIBLE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
        .SYNC_POL(0)
    ) u_neg (
        .pclk(pclk), .rst_n(rst_n), .en(en),
        .hcount_out(n_hcount), .vcount_out(n_vcount),
        .hsync_out(n_hsync), .vsync_out(n_vsync),
        .hblnk_out(n_hblnk), .vblnk_out(n_vblnk),
        .frame_start(n_fs)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Enabled edges since reset release drive the bench's raster model.
    task automatic tick();
        @(posedge pclk);
        #1;
        if (rst_n && en) cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        #3;
        vectors++;
        if (d_hcount !== 11'd0 || d_vcount !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_counts got h=%0d v=%0d exp 0 0", d_hcount, d_vcount);
        end
        repeat (3) @(posedge pclk);
        #1;
        vectors++;
        if ({d_hsync, d_vsync, d_hblnk, d_vblnk, d_fs} !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_flags got %b exp 00000",
                     {d_hsync, d_vsync, d_hblnk, d_vblnk, d_fs});
        end
        vectors++;
        if ({n_hsync, n_vsync, n_fs} !== 3'b110) begin
            miscompares++;
            $display("FAIL reset_neg_pol got %b exp 110", {n_hsync, n_vsync, n_fs});
        end
        vectors++;
        if (s_hcount !== 11'd0 || s_vcount !== 11'd0 || s_fs !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_small got h=%0d v=%0d fs=%b exp 0 0 0",
                     s_hcount, s_vcount, s_fs);
        end
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_first_edges();
        tick();
        vectors++;
        if (d_hcount !== 11'd1 || d_fs !== 1'b0) begin
            miscompares++;
            $display("FAIL first_edge got h=%0d fs=%b exp 1 0", d_hcount, d_fs);
        end
        repeat (4) tick();
        vectors++;
        if (d_hcount !== 11'd5 || d_vcount !== 11'd0) begin
            miscompares++;
            $display("FAIL five_edges got h=%0d v=%0d exp 5 0", d_hcount, d_vcount);
        end
        vectors++;
        if (d_hblnk !== 1'b0 || d_hsync !== 1'b0) begin
            miscompares++;
            $display("FAIL five_edges_flags got hblnk=%b hsync=%b exp 0 0",
                     d_hblnk, d_hsync);
        end
    endtask

    task automatic test_hline();
        int eh, ev, hs_cnt, rise_h;
        logic e_hb, e_hs;
        hs_cnt = 0;
        rise_h = -1;
        while (cyc < 1057) begin
            tick();
            eh   = cyc % 1056;
            ev   = (cyc / 1056) % 628;
            e_hb = (eh >= 800);
            e_hs = (eh >= 840) && (eh < 968);
            vectors++;
            if (d_hcount !== 11'(eh) || d_vcount !== 11'(ev)) begin
                miscompares++;
                $display("FAIL hline_count cyc=%0d got h=%0d v=%0d exp %0d %0d",
                         cyc, d_hcount, d_vcount, eh, ev);
            end
            vectors++;
            if (d_hblnk !== e_hb || d_hsync !== e_hs || d_vblnk !== 1'b0) begin
                miscompares++;
                $display("FAIL hline_decode h=%0d got hb=%b hs=%b vb=%b exp %b %b 0",
                         eh, d_hblnk, d_hsync, d_vblnk, e_hb, e_hs);
            end
            if (cyc < 1056 && d_hsync === 1'b1) hs_cnt++;
            if (rise_h < 0 && d_hblnk === 1'b1) rise_h = int'(d_hcount);
        end
        vectors++;
        if (hs_cnt != 128) begin
            miscompares++;
            $display("FAIL hsync_width got %0d exp 128", hs_cnt);
        end
        vectors++;
        if (rise_h != 800) begin
            miscompares++;
            $display("FAIL hblnk_rise got %0d exp 800", rise_h);
        end
    endtask

    task automatic test_frame();
        int sh, sv, fs_cnt, vs_cnt, vb_rise;
        logic [6:0] e;
        logic [6:0] g;
        fs_cnt  = 0;
        vs_cnt  = 0;
        vb_rise = -1;
        for (int i = 0; i < 800; i++) begin
            tick();
            sh = cyc % 25;
            sv = (cyc / 25) % 16;
            e = {sh >= 16, sv >= 10, (sh >= 18 && sh < 22),
                 (sv >= 11 && sv < 13), (sh == 0 && sv == 0), 2'b00};
            g = {s_hblnk, s_vblnk, s_hsync, s_vsync, s_fs, 2'b00};
            vectors++;
            if (s_hcount !== 11'(sh) || s_vcount !== 11'(sv)) begin
                miscompares++;
                $display("FAIL frame_count cyc=%0d got h=%0d v=%0d exp %0d %0d",
                         cyc, s_hcount, s_vcount, sh, sv);
            end
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL frame_decode h=%0d v=%0d got %b exp %b", sh, sv, g, e);
            end
            if (s_fs === 1'b1) fs_cnt++;
            if (s_vsync === 1'b1) vs_cnt++;
            if (vb_rise < 0 && s_vblnk === 1'b1) vb_rise = int'(s_vcount);
        end
        vectors++;
        if (fs_cnt != 2) begin
            miscompares++;
            $display("FAIL frame_start_count got %0d exp 2", fs_cnt);
        end
        vectors++;
        if (vs_cnt != 100) begin
            miscompares++;
            $display("FAIL vsync_cycles got %0d exp 100", vs_cnt);
        end
        vectors++;
        if (vb_rise != 10) begin
            miscompares++;
            $display("FAIL vblnk_rise got %0d exp 10", vb_rise);
        end
    endtask

    task automatic test_polarity();
        int sh, sv, lo_cnt;
        logic e_hs, e_vs;
        lo_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            sh   = cyc % 25;
            sv   = (cyc / 25) % 16;
            e_hs = !(sh >= 18 && sh < 22);
            e_vs = !(sv >= 11 && sv < 13);
            vectors++;
            if (n_hsync !== e_hs || n_vsync !== e_vs) begin
                miscompares++;
                $display("FAIL neg_pol h=%0d v=%0d got hs=%b vs=%b exp %b %b",
                         sh, sv, n_hsync, n_vsync, e_hs, e_vs);
            end
            if (n_hsync === 1'b0) lo_cnt++;
        end
        vectors++;
        if (lo_cnt != 64) begin
            miscompares++;
            $display("FAIL neg_hsync_low got %0d exp 64", lo_cnt);
        end
    endtask

    task automatic test_enable_gating();
        for (int i = 0; i < 400 && (cyc % 400) != 399; i++) tick();
        vectors++;
        if (s_hcount !== 11'd24 || s_vcount !== 11'd15) begin
            miscompares++;
            $display("FAIL gate_pos got h=%0d v=%0d exp 24 15", s_hcount, s_vcount);
        end
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (s_hcount !== 11'd24 || s_vcount !== 11'd15 || s_fs !== 1'b0 ||
                s_hblnk !== 1'b1 || s_vblnk !== 1'b1 || s_vsync !== 1'b0) begin
                miscompares++;
                $display("FAIL gate_hold i=%0d got h=%0d v=%0d fs=%b hb=%b vb=%b vs=%b exp 24 15 0 1 1 0",
                         i, s_hcount, s_vcount, s_fs, s_hblnk, s_vblnk, s_vsync);
            end
        end
        en = 1'b1;
        tick();
        vectors++;
        if (s_hcount !== 11'd0 || s_vcount !== 11'd0 || s_fs !== 1'b1) begin
            miscompares++;
            $display("FAIL gate_resume got h=%0d v=%0d fs=%b exp 0 0 1",
                     s_hcount, s_vcount, s_fs);
        end
        vectors++;
        if ({s_hblnk, s_vblnk, s_hsync, s_vsync} !== 4'b0000) begin
            miscompares++;
            $display("FAIL gate_resume_flags got %b exp 0000",
                     {s_hblnk, s_vblnk, s_hsync, s_vsync});
        end
        tick();
        vectors++;
        if (s_hcount !== 11'd1 || s_fs !== 1'b0) begin
            miscompares++;
            $display("FAIL gate_pulse_len got h=%0d fs=%b exp 1 0", s_hcount, s_fs);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 400 && (cyc % 400) != 294; i++) tick();
        vectors++;
        if (s_hcount !== 11'd19 || s_vcount !== 11'd11 || s_hsync !== 1'b1 ||
            s_vsync !== 1'b1 || n_hsync !== 1'b0 || n_vsync !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_reset got h=%0d v=%0d hs=%b vs=%b nhs=%b nvs=%b exp 19 11 1 1 0 0",
                     s_hcount, s_vcount, s_hsync, s_vsync, n_hsync, n_vsync);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (s_hcount !== 11'd0 || s_vcount !== 11'd0 || s_hsync !== 1'b0 ||
            s_vsync !== 1'b0 || s_vblnk !== 1'b0 || s_hblnk !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_small got h=%0d v=%0d hs=%b vs=%b vb=%b hb=%b exp all 0",
                     s_hcount, s_vcount, s_hsync, s_vsync, s_vblnk, s_hblnk);
        end
        vectors++;
        if (n_hsync !== 1'b1 || n_vsync !== 1'b1 || d_hcount !== 11'd0 ||
            d_hsync !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_other got nhs=%b nvs=%b dh=%0d dhs=%b exp 1 1 0 0",
                     n_hsync, n_vsync, d_hcount, d_hsync);
        end
        repeat (2) @(posedge pclk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        tick();
        vectors++;
        if (s_hcount !== 11'd1 || s_fs !== 1'b0 || d_hcount !== 11'd1) begin
            miscompares++;
            $display("FAIL post_reset got sh=%0d fs=%b dh=%0d exp 1 0 1",
                     s_hcount, s_fs, d_hcount);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        test_reset();
        test_first_edges();
        test_hline();
        test_frame();
        test_polarity();
        test_enable_gating();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
